// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - clocked ALU with single-cycle ops plus iterative unsigned MULT/DIVU
module alu_multicycle #(
    parameter int WIDTH       = 32,
    parameter int CTRL_WIDTH  = 4,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [CTRL_WIDTH-1:0] ALUControl,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    output logic                  Out_Valid,
    output logic [WIDTH-1:0]      ALUResult,
    output logic [WIDTH-1:0]      ALUResultHi,
    output logic                  Zero_flag,
    output logic                  Overflow_flag,
    output logic                  DivZero_flag
);
    localparam int CW = SHAMT_WIDTH + 1;

    localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(4'b0000);
    localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(4'b0001);
    localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(4'b0010);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4'b0011);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(4'b0100);
    localparam logic [CTRL_WIDTH-1:0] OP_MULT = CTRL_WIDTH'(4'b0101);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(4'b0110);
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(4'b0111);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(4'b1000);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(4'b1001);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(4'b1010);
    localparam logic [CTRL_WIDTH-1:0] OP_NOR  = CTRL_WIDTH'(4'b1011);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU = CTRL_WIDTH'(4'b1100);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opnd, hi, lo;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [WIDTH:0]   mul_sum, div_sh, div_trial;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic             div_ge, accept, is_mul, is_div, div_by_zero;

    assign In_Ready    = (state == IDLE);
    assign Out_Valid   = (state == DONE);
    assign accept      = In_Valid && In_Ready;
    assign is_mul      = (ALUControl == OP_MULT);
    assign is_div      = (ALUControl == OP_DIVU);
    assign div_by_zero = (SrcB == '0);
    assign shamt       = SrcB[SHAMT_WIDTH-1:0];
    assign sum         = SrcA + SrcB;
    assign diff        = SrcA - SrcB;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUControl)
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(SrcA) < $signed(SrcB));
            OP_SLTU: alu_res = WIDTH'(SrcA < SrcB);
            OP_SLL:  alu_res = SrcA << shamt;
            OP_SRL:  alu_res = SrcA >> shamt;
            OP_SRA:  alu_res = $signed(SrcA) >>> shamt;
            OP_NOR:  alu_res = ~(SrcA | SrcB);
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply: {hi, lo} shifts right, lo starts as the multiplier.
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

    // Restoring divide: lo starts as the dividend and fills with quotient bits.
    assign div_sh    = {hi, lo[WIDTH-1]};
    assign div_trial = div_sh - {1'b0, opnd};
    assign div_ge    = !div_trial[WIDTH];
    assign div_hi_n  = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_n  = {lo[WIDTH-2:0], div_ge};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)                     next_state = MUL;
                else if (is_div && !div_by_zero) next_state = DIV;
                else                            next_state = DONE;
            end
            MUL:  if (count == CW'(1)) next_state = DONE;
            DIV:  if (count == CW'(1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count         <= '0;
            opnd          <= '0;
            hi            <= '0;
            lo            <= '0;
            ALUResult     <= '0;
            ALUResultHi   <= '0;
            Zero_flag     <= 1'b1;
            Overflow_flag <= 1'b0;
            DivZero_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_mul) begin
                        opnd  <= SrcA;
                        lo    <= SrcB;
                        hi    <= '0;
                        count <= CW'(WIDTH);
                    end else if (is_div && !div_by_zero) begin
                        opnd  <= SrcB;
                        lo    <= SrcA;
                        hi    <= '0;
                        count <= CW'(WIDTH);
                    end else if (is_div) begin
                        ALUResult     <= '1;
                        ALUResultHi   <= SrcA;
                        Zero_flag     <= 1'b0;
                        Overflow_flag <= 1'b0;
                        DivZero_flag  <= 1'b1;
                    end else begin
                        ALUResult     <= alu_res;
                        ALUResultHi   <= '0;
                        Zero_flag     <= (alu_res == '0);
                        Overflow_flag <= alu_ovf;
                        DivZero_flag  <= 1'b0;
                    end
                end
                MUL: begin
                    hi    <= mul_hi_n;
                    lo    <= mul_lo_n;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        ALUResult     <= mul_lo_n;
                        ALUResultHi   <= mul_hi_n;
                        Zero_flag     <= (mul_lo_n == '0);
                        Overflow_flag <= 1'b0;
                        DivZero_flag  <= 1'b0;
                    end
                end
                DIV: begin
                    hi    <= div_hi_n;
                    lo    <= div_lo_n;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        ALUResult     <= div_lo_n;
                        ALUResultHi   <= div_hi_n;
                        Zero_flag     <= (div_lo_n == '0);
                        Overflow_flag <= 1'b0;
                        DivZero_flag  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - vector table plus scoreboard bench for alu_multicycle
module tb_alu_multicycle;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_control = '0;
    logic [W-1:0]  src_a = '0, src_b = '0;
    logic          out_valid;
    logic [W-1:0]  alu_result, alu_result_hi;
    logic          zero_flag, overflow_flag, divzero_flag;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a, b, lo, hi;
        logic         z, ov, dz;
        int           lat;
    } vec_t;

    vec_t exp_q[$];

    alu_multicycle #(.WIDTH(W), .CTRL_WIDTH(4), .SHAMT_WIDTH(5)) dut (
        .CLK(clk), .RST(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
        .ALUControl(alu_control), .SrcA(src_a), .SrcB(src_b),
        .Out_Valid(out_valid), .ALUResult(alu_result), .ALUResultHi(alu_result_hi),
        .Zero_flag(zero_flag), .Overflow_flag(overflow_flag), .DivZero_flag(divzero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] lo, input logic [W-1:0] hi,
                                input logic z, input logic ov, input logic dz, input int lat);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
        v.z = z; v.ov = ov; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    // Issue one op, push its expectation, then pop/compare on Out_Valid.
    // inject > 0 drives a stray request at that cycle count while busy.
    task automatic run_op(input vec_t v, input int inject);
        vec_t e;
        int   cnt;
        bit   busy_ok;
        @(negedge clk);
        check("ready_before_accept", W'(in_ready), W'(1));
        alu_control = v.ctrl; src_a = v.a; src_b = v.b; in_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; alu_control = 4'b0010;
        cnt = 1;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
            cnt++;
            if (cnt == inject) in_valid = 1'b1;
            if (cnt > 2 * W + 8) break;
        end
        in_valid = 1'b0;
        check("latency", W'(cnt), W'(v.lat));
        if (v.lat > 1) check("busy_not_ready", W'(busy_ok), W'(1));
        if (out_valid) begin
            e = exp_q.pop_front();
            check("ready_in_done", W'(in_ready), W'(0));
            check("result_lo", alu_result, e.lo);
            check("result_hi", alu_result_hi, e.hi);
            check("zero_flag", W'(zero_flag), W'(e.z));
            check("ovf_flag", W'(overflow_flag), W'(e.ov));
            check("divzero_flag", W'(divzero_flag), W'(e.dz));
        end else begin
            exp_q.delete();
        end
        @(negedge clk);
        check("valid_single_pulse", W'(out_valid), W'(0));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 1));
        vecs.push_back(mk(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0100, 32'd5,         32'd5,         32'd0,         0, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1, 0, 1));
        vecs.push_back(mk(4'b0110, 32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1, 0, 0, 1));
        vecs.push_back(mk(4'b1000, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1001, 32'h8000_0000, 32'd31,        32'h0000_0001, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0, 1, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", alu_result, 0);
        check("reset_result_hi", alu_result_hi, 0);
        check("reset_zero", W'(zero_flag), W'(1));
        check("reset_valid", W'(out_valid), W'(0));
        check("reset_ovf", W'(overflow_flag), W'(0));
        check("reset_divzero", W'(divzero_flag), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", W'(in_ready), W'(1));

        foreach (vecs[i]) run_op(vecs[i], 0);

        run_op(mk(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0, W + 1), 10);
        repeat (3) begin
            @(negedge clk);
            check("stray_request_ignored", W'(out_valid), W'(0));
        end
        run_op(mk(4'b0101, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 0, 0, 0, W + 1), 0);
        run_op(mk(4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, W + 1), 0);
        run_op(mk(4'b1100, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 0, 1, 1), 0);
        run_op(mk(4'b1100, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 0, 0, 0, W + 1), 0);
        run_op(mk(4'b1100, 32'd3, 32'd8, 32'd0, 32'd3, 1, 0, 0, W + 1), 0);

        // Reset in the middle of a MULT aborts it without a completion pulse.
        @(negedge clk);
        alu_control = 4'b0101; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1234; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", alu_result, 0);
        check("abort_result_hi", alu_result_hi, 0);
        check("abort_zero", W'(zero_flag), W'(1));
        check("abort_divzero", W'(divzero_flag), W'(0));
        check("abort_valid", W'(out_valid), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            bit saw_valid = 1'b0;
            repeat (W + 8) begin
                @(negedge clk);
                if (out_valid) saw_valid = 1'b1;
            end
            check("no_valid_after_abort", W'(saw_valid), W'(0));
        end
        run_op(mk(4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, clocked successor to the single-cycle ALU.
- Adds signed/unsigned compares, shifts, XOR/NOR and a signed-overflow flag.
- Adds iterative unsigned multiply and divide (one bit per cycle) with HI/LO-style double-width results.
- Sits in the execute stage of the multi-cycle datapath.
- The controller issues an operation through a valid/ready handshake and waits for the result-valid pulse.

Parameters:
- WIDTH, 32, operand and result width. Must be an even value ≥ 8.
- CTRL_WIDTH, 4, width of ALUControl.
- SHAMT_WIDTH, 5, shift-amount bits taken from SrcB[SHAMT_WIDTH-1:0]. Must equal clog2(WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- In_Valid  in  1  operation request.
- In_Ready  out  1  block can accept an operation.
- ALUControl  in  CTRL_WIDTH  operation select, sampled on accept.
- SrcA  in  WIDTH  operand A, sampled on accept.
- SrcB  in  WIDTH  operand B, sampled on accept.
- Out_Valid  out  1  one-cycle pulse: result outputs updated.
- ALUResult  out  WIDTH  result (product LO / quotient for MULT/DIVU).
- ALUResultHi  out  WIDTH  product HI / remainder. Zero for all single-cycle ops.
- Zero_flag  out  1  ALUResult == 0.
- Overflow_flag  out  1  signed overflow of ADD/SUB. 0 otherwise.
- DivZero_flag  out  1  DIVU with SrcB == 0.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: ALUResult = 0, ALUResultHi = 0, Out_Valid = 0, Overflow_flag = 0, DivZero_flag = 0, Zero_flag = 1.
  - Internal: state = IDLE, counter = 0.
  - Reset asserted mid-operation aborts that operation; no Out_Valid is produced for it.
- Accept:
  - An operation is accepted on a rising edge where In_Valid = 1 and In_Ready = 1.
  - In_Ready = 1 only in IDLE.
  - In_Valid while not in IDLE is ignored; the request is not queued.
- Opcodes, single-cycle group:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB.
  - 0110 SLT: signed; result 1 or 0.
  - 0111 SLTU: unsigned; result 1 or 0.
  - 1000 SLL, 1001 SRL, 1010 SRA: SrcA shifted by SrcB[SHAMT_WIDTH-1:0].
  - 1011 NOR.
  - Unused codes return 0.
- Opcodes, iterative group:
  - 0101 MULT: unsigned WIDTH×WIDTH giving 2·WIDTH bits. {ALUResultHi, ALUResult} = product.
  - 1100 DIVU: unsigned restoring division. ALUResult = quotient, ALUResultHi = remainder.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Overflow_flag = 1 when the operand signs allow overflow and the result sign differs from the expected sign.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE, accept, single-cycle op: results registered on the accept edge; go to DONE.
  - IDLE, accept, MULT: load the multiplicand, multiplier and accumulator, counter = WIDTH; go to MUL.
  - IDLE, accept, DIVU with SrcB ≠ 0: counter = WIDTH; go to DIV.
  - IDLE, accept, DIVU with SrcB == 0: go to DONE immediately with ALUResult = all-ones, ALUResultHi = SrcA, DivZero_flag = 1.
  - MUL and DIV: one bit per cycle, counter decrements. At counter == 1 the final step writes the outputs; go to DONE.
  - DONE: Out_Valid = 1 for exactly this cycle, In_Ready = 0; go to IDLE.
- Latency, counted from the accept edge to the edge on which Out_Valid is observed high:
  - Single-cycle ops and DIVU by zero: 1 cycle.
  - MULT and DIVU: WIDTH+1 cycles.
- Minimum spacing between two accepts: 2 cycles for single-cycle ops.
- Output update and hold:
  - Zero_flag, Overflow_flag and DivZero_flag update only together with ALUResult.
  - All result outputs hold their value until the next completion.
  - Operand changes after accept have no effect.
- Operand edge cases:
  - Shift amounts use only the low SHAMT_WIDTH bits.
  - SRA replicates SrcA[WIDTH-1].
- No backpressure on results: a consumer must capture them on Out_Valid or read the held values later.

Test Plan:
- Reset asserted with no operation → ALUResult = 0, Zero_flag = 1, In_Ready = 1 after release.
- ADD 0x7FFFFFFF + 0x00000001 → 1 cycle later: Out_Valid = 1, ALUResult = 0x80000000, Overflow_flag = 1, Zero_flag = 0.
- SUB 5 − 5 → ALUResult = 0, Zero_flag = 1. Then:
  - SLT 0xFFFFFFFF vs 1 → ALUResult = 1.
  - SLTU 0xFFFFFFFF vs 1 → ALUResult = 0.
  - SRA 0x80000000 by SrcB = 0x24 (shift 4) → ALUResult = 0xF8000000.
- MULT 0xFFFFFFFF × 0xFFFFFFFF → In_Ready = 0 for 32 cycles; Out_Valid on cycle 33; ALUResultHi = 0xFFFFFFFE, ALUResult = 0x00000001. A second In_Valid at cycle 10 is ignored.
- DIVU 100 / 7 → cycle 33: ALUResult = 14, ALUResultHi = 2, DivZero_flag = 0. DIVU 9 / 0 → cycle 1: ALUResult = 0xFFFFFFFF, ALUResultHi = 9, DivZero_flag = 1.
- Start MULT, assert RST at cycle 12 → outputs cleared asynchronously; no Out_Valid; after release ADD 2 + 3 returns 5 with normal 1-cycle latency.
